// File: rtl/fifo_burst_reader.sv
// Read-side burst scheduler for a dual-clock FIFO: turns word-count/empty status into
// valid/ready bursts, with timeout/flush of partial bursts and a sequenced FIFO clear.
module fifo_burst_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int BURST_LEN     = 8,
  parameter int TIMEOUT       = 64,
  parameter int CLEAR_CYCLES  = 4
) (
  input  logic                     Clk,
  input  logic                     Rstn_in,
  input  logic                     Enable_in,
  input  logic                     Flush_in,
  input  logic                     ClearReq_in,
  input  logic [DATA_WIDTH-1:0]    Fifo_Data_in,
  input  logic                     Fifo_Empty_in,
  input  logic [ADDRESS_WIDTH-1:0] Fifo_WordCount_in,
  output logic                     Fifo_ReadEn_out,
  output logic                     Fifo_Clear_out,
  output logic [DATA_WIDTH-1:0]    M_Data_out,
  output logic                     M_Valid_out,
  output logic                     M_Last_out,
  input  logic                     M_Ready_in,
  output logic                     Busy_out,
  output logic [15:0]              BurstCount_out
);

  localparam int CNT_W = ADDRESS_WIDTH + 1;
  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(2 ** ADDRESS_WIDTH);
  localparam logic [TMO_W-1:0] TIMEOUT_C   = TMO_W'(TIMEOUT);
  localparam logic [CLR_W-1:0] CLR_LAST_C  = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DRAIN, ST_CLEAR} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] issued_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [CLR_W-1:0] clr_cnt_reg;
  logic             flush_pend_reg;
  logic             clear_pend_reg;
  logic             clear_reg;
  logic [15:0]      burst_cnt_reg;

  logic [DATA_WIDTH-1:0] buf_data_reg [2];
  logic                  buf_last_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            occ_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;

  logic [CNT_W-1:0] avail;
  logic [2:0]       slots;
  logic             m_valid;
  logic             pop;
  logic             rd_en;
  logic             eff_rd;
  logic             rd_is_last;

  // A zero count with the FIFO not empty means the pointer difference wrapped: full.
  assign avail = (Fifo_WordCount_in == '0 && !Fifo_Empty_in) ? FULL_C
                                                             : {1'b0, Fifo_WordCount_in};

  assign m_valid    = (occ_reg != 2'd0);
  assign pop        = m_valid & M_Ready_in;
  // The beat leaving this cycle frees its slot, which keeps one beat per cycle streaming.
  assign slots      = {1'b0, occ_reg} + {2'b0, inflight_reg} - {2'b0, pop};
  assign rd_en      = (state_reg == ST_BURST) && (issued_reg < len_reg) && (slots < 3'd2);
  assign eff_rd     = rd_en & ~Fifo_Empty_in;
  assign rd_is_last = (issued_reg == len_reg - CNT_W'(1));

  assign Fifo_ReadEn_out = rd_en;
  assign Fifo_Clear_out  = clear_reg;
  assign M_Valid_out     = m_valid;
  assign M_Data_out      = buf_data_reg[rd_ptr_reg];
  assign M_Last_out      = buf_last_reg[rd_ptr_reg] & m_valid;
  assign Busy_out        = (state_reg != ST_IDLE) || m_valid;
  assign BurstCount_out  = burst_cnt_reg;

  always_ff @(posedge Clk or negedge Rstn_in) begin
    if (!Rstn_in) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_reg[i] <= '0;
        buf_last_reg[i] <= 1'b0;
      end
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      occ_reg           <= 2'd0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= eff_rd;
      inflight_last_reg <= eff_rd & rd_is_last;
      if (inflight_reg) begin
        buf_data_reg[wr_ptr_reg] <= Fifo_Data_in;
        buf_last_reg[wr_ptr_reg] <= inflight_last_reg;
        wr_ptr_reg               <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  always_ff @(posedge Clk or negedge Rstn_in) begin
    if (!Rstn_in) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      issued_reg     <= '0;
      tmo_reg        <= '0;
      clr_cnt_reg    <= '0;
      flush_pend_reg <= 1'b0;
      clear_pend_reg <= 1'b0;
      clear_reg      <= 1'b0;
      burst_cnt_reg  <= '0;
    end else begin
      if (ClearReq_in) begin
        clear_pend_reg <= 1'b1;
      end else if (Flush_in) begin
        flush_pend_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (Fifo_Empty_in) begin
            tmo_reg <= '0;
          end else if (avail < BURST_LEN_C && tmo_reg != TIMEOUT_C) begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end

          if (clear_pend_reg && occ_reg == 2'd0) begin
            state_reg   <= ST_CLEAR;
            clear_reg   <= 1'b1;
            clr_cnt_reg <= '0;
            tmo_reg     <= '0;
          end else if (Enable_in && avail >= BURST_LEN_C) begin
            state_reg      <= ST_BURST;
            len_reg        <= BURST_LEN_C;
            issued_reg     <= '0;
            flush_pend_reg <= 1'b0;
            tmo_reg        <= '0;
          end else if (Enable_in && avail != '0 &&
                       (flush_pend_reg || (TIMEOUT != 0 && tmo_reg == TIMEOUT_C))) begin
            state_reg      <= ST_BURST;
            len_reg        <= avail;
            issued_reg     <= '0;
            flush_pend_reg <= 1'b0;
            tmo_reg        <= '0;
          end
        end

        ST_BURST: begin
          if (eff_rd) begin
            issued_reg <= issued_reg + CNT_W'(1);
            if (rd_is_last) begin
              state_reg <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (pop && buf_last_reg[rd_ptr_reg]) begin
            burst_cnt_reg <= burst_cnt_reg + 16'd1;
            state_reg     <= ST_IDLE;
          end
        end

        ST_CLEAR: begin
          if (clr_cnt_reg == CLR_LAST_C) begin
            clear_reg      <= 1'b0;
            clear_pend_reg <= 1'b0;
            flush_pend_reg <= 1'b0;
            state_reg      <= ST_IDLE;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench: two readers (BURST_LEN 8 with timeout, BURST_LEN 15 without) each fed
// by a small behavioural FIFO with one-cycle registered read data.
module tb_fifo_burst_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic en [2];
  logic flush [2];
  logic clr_req [2];
  logic ready [2];
  logic wr_en [2];
  logic [7:0] wr_data [2];
  logic rd_en [2];
  logic fclr [2];
  logic fifo_empty [2];
  logic m_valid [2];
  logic m_last [2];
  logic busy [2];
  logic [7:0] fifo_data [2];
  logic [7:0] m_data [2];
  logic [3:0] fifo_count [2];
  logic [15:0] burst_cnt [2];

  int total = 0;
  int bad = 0;
  logic [8:0] beats0 [$];
  logic [8:0] beats1 [$];
  int stall_viol = 0;
  int outst = 0;
  int max_outst = 0;
  logic prev_stall = 1'b0;
  logic [8:0] prev_beat = '0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic [7:0] mem [16];
    logic [3:0] wp = '0;
    logic [3:0] rp = '0;
    logic [4:0] cnt = '0;
    logic [7:0] rdata = '0;
    logic eff;
    logic push;

    assign eff  = rd_en[gi] & (cnt != 5'd0);
    assign push = wr_en[gi] & (cnt != 5'd16);

    always @(posedge clk) begin
      if (fclr[gi]) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          mem[wp] <= wr_data[gi];
          wp      <= wp + 4'd1;
        end
        if (eff) begin
          rdata <= mem[rp];
          rp    <= rp + 4'd1;
        end
        cnt <= cnt + {4'd0, push} - {4'd0, eff};
      end
    end

    assign fifo_empty[gi] = (cnt == 5'd0);
    assign fifo_count[gi] = cnt[3:0];
    assign fifo_data[gi]  = rdata;

    fifo_burst_reader #(
      .DATA_WIDTH   (8),
      .ADDRESS_WIDTH(4),
      .BURST_LEN    ((gi == 0) ? 8 : 15),
      .TIMEOUT      ((gi == 0) ? 64 : 0),
      .CLEAR_CYCLES (4)
    ) dut (
      .Clk              (clk),
      .Rstn_in          (rst_n),
      .Enable_in        (en[gi]),
      .Flush_in         (flush[gi]),
      .ClearReq_in      (clr_req[gi]),
      .Fifo_Data_in     (fifo_data[gi]),
      .Fifo_Empty_in    (fifo_empty[gi]),
      .Fifo_WordCount_in(fifo_count[gi]),
      .Fifo_ReadEn_out  (rd_en[gi]),
      .Fifo_Clear_out   (fclr[gi]),
      .M_Data_out       (m_data[gi]),
      .M_Valid_out      (m_valid[gi]),
      .M_Last_out       (m_last[gi]),
      .M_Ready_in       (ready[gi]),
      .Busy_out         (busy[gi]),
      .BurstCount_out   (burst_cnt[gi])
    );
  end

  // Capture accepted beats, watch stall stability and reads outstanding against the buffer.
  always @(posedge clk) begin
    if (m_valid[0] && ready[0]) beats0.push_back({m_last[0], m_data[0]});
    if (m_valid[1] && ready[1]) beats1.push_back({m_last[1], m_data[1]});
    if (prev_stall && (!m_valid[0] || {m_last[0], m_data[0]} !== prev_beat)) stall_viol++;
    prev_stall = m_valid[0] & ~ready[0];
    prev_beat  = {m_last[0], m_data[0]};
    if (!rst_n) begin
      outst = 0;
    end else begin
      outst = outst + int'(rd_en[0] & ~fifo_empty[0]) - int'(m_valid[0] & ready[0]);
      if (outst > max_outst) max_outst = outst;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_words(input int gi, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en[gi]   = 1'b1;
      wr_data[gi] = base + 8'(i);
      @(negedge clk);
    end
    wr_en[gi] = 1'b0;
  endtask

  task automatic pulse_flush(input int gi);
    flush[gi] = 1'b1;
    @(negedge clk);
    flush[gi] = 1'b0;
  endtask

  task automatic wait_burst(input int gi, input logic [15:0] target, input int bound, input string tag);
    int n = 0;
    while (burst_cnt[gi] !== target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(burst_cnt[gi]), 32'(target));
  endtask

  task automatic check_q(input int gi, input string tag, input logic [7:0] base,
                         input int n, input int extra_last);
    int sz;
    logic [8:0] got;
    logic [8:0] exp;
    sz = (gi == 0) ? beats0.size() : beats1.size();
    chk($sformatf("%s beat count", tag), 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++) begin
      got    = (gi == 0) ? beats0[i] : beats1[i];
      exp    = {1'b0, base + 8'(i)};
      exp[8] = (i == n - 1) || (i == extra_last);
      chk($sformatf("%s beat%0d", tag, i), 32'(got), 32'(exp));
    end
  endtask

  initial begin
    int n;
    int hi;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; flush[i] = 1'b0; clr_req[i] = 1'b0;
      ready[i] = 1'b1; wr_en[i] = 1'b0; wr_data[i] = '0;
    end
    rst_n = 1'b0;
    tick(3);
    chk("reset valid", 32'(m_valid[0]), 0);
    chk("reset rden", 32'(rd_en[0]), 0);
    chk("reset clear", 32'(fclr[0]), 0);
    chk("reset busy", 32'(busy[0]), 0);
    chk("reset data", 32'(m_data[0]), 0);
    chk("reset count", 32'(burst_cnt[0]), 0);
    rst_n = 1'b1;
    tick(2);

    // Full-length burst
    en[0] = 1'b1;
    write_words(0, 8'h10, 8);
    wait_burst(0, 16'd1, 60, "full burst done");
    check_q(0, "full", 8'h10, 8, -1);
    chk("full idle after", 32'(busy[0]), 0);

    // Partial burst forced by timeout
    beats0.delete();
    write_words(0, 8'h20, 3);
    tick(55);
    chk("timeout early beats", 32'(beats0.size()), 0);
    chk("timeout early busy", 32'(busy[0]), 0);
    wait_burst(0, 16'd2, 40, "timeout burst done");
    check_q(0, "timeout", 8'h20, 3, -1);

    // Partial burst requested by flush
    beats0.delete();
    write_words(0, 8'h30, 3);
    pulse_flush(0);
    n = 0;
    while (!rd_en[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("flush latency", 32'(n <= 3), 1);
    wait_burst(0, 16'd3, 30, "flush burst done");
    check_q(0, "flush", 8'h30, 3, -1);
    beats0.delete();
    write_words(0, 8'h33, 1);
    tick(10);
    chk("flush flag cleared", 32'(busy[0]), 0);
    pulse_flush(0);
    wait_burst(0, 16'd4, 30, "single burst done");
    check_q(0, "single", 8'h33, 1, -1);

    // Backpressure with a 5-cycle stall
    beats0.delete();
    write_words(0, 8'h40, 8);
    n = 0;
    while (!rd_en[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 30; i++) begin
      ready[0] = (i >= 4 && i < 9) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ready[0] = 1'b1;
    wait_burst(0, 16'd5, 40, "stall burst done");
    check_q(0, "stall", 8'h40, 8, -1);
    chk("stall stability", 32'(stall_viol), 0);
    chk("buffer bound", 32'(max_outst <= 2), 1);

    // Clear request deferred until the burst completes
    beats0.delete();
    write_words(0, 8'h50, 11);
    chk("clear mid burst busy", 32'(busy[0]), 1);
    clr_req[0] = 1'b1;
    @(negedge clk);
    clr_req[0] = 1'b0;
    wait_burst(0, 16'd6, 40, "clear burst done");
    n = 0;
    hi = 0;
    while (n < 40 && !(hi > 0 && !fclr[0])) begin
      if (fclr[0]) hi++;
      @(negedge clk);
      n++;
    end
    chk("clear cycles", 32'(hi), 4);
    chk("fifo empty after clear", 32'(fifo_empty[0]), 1);
    check_q(0, "clear", 8'h50, 8, -1);

    // Completely full FIFO on the BURST_LEN=15 reader
    write_words(1, 8'h60, 16);
    chk("full fifo count", 32'(fifo_count[1]), 0);
    chk("full fifo empty", 32'(fifo_empty[1]), 0);
    en[1] = 1'b1;
    wait_burst(1, 16'd1, 60, "wrap burst15 done");
    tick(10);
    chk("wrap idle", 32'(busy[1]), 0);
    chk("wrap first size", 32'(beats1.size()), 15);
    pulse_flush(1);
    wait_burst(1, 16'd2, 30, "wrap burst1 done");
    check_q(1, "wrap", 8'h60, 16, 14);

    // Asynchronous reset in the middle of a burst
    beats0.delete();
    write_words(0, 8'h70, 8);
    n = 0;
    while (!m_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst mid busy", 32'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst mid valid", 32'(m_valid[0]), 0);
    chk("rst mid rden", 32'(rd_en[0]), 0);
    chk("rst mid last", 32'(m_last[0]), 0);
    chk("rst mid data", 32'(m_data[0]), 0);
    chk("rst mid busy low", 32'(busy[0]), 0);
    chk("rst mid count", 32'(burst_cnt[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release busy", 32'(busy[0]), 0);
    chk("rst release count", 32'(burst_cnt[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
